// File: rtl/flipflop_bank.sv
// flipflop_bank: WIDTH-bit SR/JK/D/T register bank (clk, rst, en, mode, a, b -> q, qbar, sr_err, err_cnt, changed)
module flipflop_bank #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic                 sr_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 changed
);
  logic [WIDTH-1:0] nq;
  logic ill;
  assign qbar = ~q;
  always_comb begin
    nq = !en ? q :
         mode == 2'b00 ? (a & ~b) | (q & ~(a ^ b)) :
         mode == 2'b01 ? (a & ~q) | (~b & q) :
         mode == 2'b10 ? a : q ^ a;
    ill = en && mode == 2'b00 && |(a & b);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_VAL;
      sr_err  <= 1'b0;
      err_cnt <= '0;
      changed <= 1'b0;
    end else begin
      q       <= nq;
      sr_err  <= ill;
      err_cnt <= (ill && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
      changed <= nq != q;
    end
  end
endmodule

// File: tb/tb_flipflop_bank.sv
// tb_flipflop_bank: randomized and directed check of flipflop_bank against a per-bit behavioural model
module tb_flipflop_bank;
  logic clk = 1'b0;
  logic rst, en;
  logic [1:0] mode;
  logic [3:0] a, b, q, qbar;
  logic sr_err, changed;
  logic [1:0] err_cnt;
  int checks = 0;
  int errors = 0;
  bit valid = 0;
  logic [3:0] mq;
  bit msr, mch;
  int mcnt;

  flipflop_bank #(.WIDTH(4), .RST_VAL(4'b0000), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .q(q), .qbar(qbar), .sr_err(sr_err), .err_cnt(err_cnt), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] nxt;
    bit bad;
    if (rst) begin
      mq = 4'b0000; msr = 0; mcnt = 0; mch = 0; valid = 1;
    end else if (!en) begin
      msr = 0; mch = 0;
    end else begin
      nxt = mq;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        case (mode)
          2'd0: begin
            if (a[i] && !b[i]) nxt[i] = 1'b1;
            else if (!a[i] && b[i]) nxt[i] = 1'b0;
            else if (a[i] && b[i]) bad = 1;
          end
          2'd1: begin
            if (a[i] && b[i]) nxt[i] = !mq[i];
            else if (a[i]) nxt[i] = 1'b1;
            else if (b[i]) nxt[i] = 1'b0;
          end
          2'd2: nxt[i] = a[i];
          default: if (a[i]) nxt[i] = !mq[i];
        endcase
      end
      mch = nxt != mq;
      msr = bad;
      if (bad && mcnt < 3) mcnt++;
      mq = nxt;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("model_q", q, mq);
      chk("model_qbar", qbar, ~mq & 4'hF);
      chk("model_sr_err", sr_err, msr);
      chk("model_err_cnt", err_cnt, mcnt);
      chk("model_changed", changed, mch);
    end
  end

  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [3:0] aa, input logic [3:0] bb);
    rst = r; en = e; mode = m; a = aa; b = bb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; en = 1; mode = 2; a = 4'hF; b = 0;
    step(1, 1, 2, 4'hF, 4'h0);
    step(1, 1, 2, 4'hF, 4'h0);
    chk("rst_q", q, 0); chk("rst_qbar", qbar, 15); chk("rst_sr_err", sr_err, 0);
    chk("rst_err_cnt", err_cnt, 0); chk("rst_changed", changed, 0);
    step(0, 1, 0, 4'b0011, 4'b0100);
    chk("sr_set_q", q, 4'b0011); chk("sr_set_changed", changed, 1);
    step(0, 1, 0, 4'b0000, 4'b0000);
    chk("sr_hold_q", q, 4'b0011); chk("sr_hold_changed", changed, 0);
    step(0, 1, 0, 4'b1001, 4'b0001);
    chk("sr_ill_q", q, 4'b1011); chk("sr_ill_qbar", qbar, 4'b0100);
    chk("sr_ill_sr_err", sr_err, 1); chk("sr_ill_err_cnt", err_cnt, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 4'b0001, 4'b0001);
      chk("sat_err_cnt", err_cnt, i < 3 ? i + 1 : 3);
      chk("sat_sr_err", sr_err, 1);
    end
    step(0, 1, 0, 0, 0);
    chk("sat_clear_sr_err", sr_err, 0); chk("sat_hold_err_cnt", err_cnt, 3);
    step(0, 1, 2, 4'b0101, 0);
    chk("d_load_q", q, 4'b0101);
    step(0, 1, 1, 4'hF, 4'hF);
    chk("jk_toggle_q", q, 4'b1010);
    step(0, 1, 3, 4'b0011, 4'hA);
    chk("t_toggle_q", q, 4'b1001);
    step(0, 1, 3, 4'b0000, 4'hF);
    chk("t_hold_q", q, 4'b1001); chk("t_hold_changed", changed, 0);
    step(0, 0, 0, 4'hF, 4'hF);
    chk("en0_q", q, 4'b1001); chk("en0_sr_err", sr_err, 0); chk("en0_err_cnt", err_cnt, 3);
    step(0, 1, 2, 4'b0110, 4'hF);
    chk("d_q", q, 4'b0110); chk("d_changed", changed, 1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 4'b0010, 4'b0010);
    step(0, 1, 0, 4'b0010, 4'b0010);
    chk("mid_err_cnt", err_cnt, 2);
    step(1, 1, 0, 4'hF, 4'hF);
    chk("mid_rst_q", q, 0); chk("mid_rst_err_cnt", err_cnt, 0); chk("mid_rst_sr_err", sr_err, 0);
    step(0, 1, 0, 4'b0001, 4'b0000);
    chk("post_rst_q", q, 4'b0001);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) != 0, 2'($urandom),
           4'($urandom), 4'($urandom));
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
